// File: rtl/clk_div_sequencer.sv
// Runtime-reconfigurable even-integer clock divider. Produces the divided clock, its
// divided-domain reset and edge enables, and applies divisor changes only at a falling boundary.
module clk_div_sequencer #(
  parameter int unsigned par_div_width   = 16,
  parameter int unsigned par_div_default = 1000,
  parameter int unsigned par_div_min     = 4
) (
  input  logic                     i_clk_mhz,
  input  logic                     i_rst_mhz,
  input  logic                     i_div_req,
  input  logic [par_div_width-1:0] i_div_value,
  output logic                     o_div_ack,
  output logic                     o_div_err,
  output logic                     o_busy,
  output logic                     o_clk_div,
  output logic                     o_rst_div,
  output logic                     o_ce_rise,
  output logic                     o_ce_fall
);

  localparam int unsigned CntW = par_div_width - 1;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [par_div_width-1:0] div_q, div_d;
  logic [par_div_width-1:0] pend_q, pend_d;
  logic                     clk_div_q, clk_div_d;
  logic                     rst_div_q, rst_div_d;
  logic                     ce_rise_q, ce_rise_d;
  logic                     ce_fall_q, ce_fall_d;
  logic                     ack_q, ack_d;
  logic                     err_q, err_d;

  logic [CntW-1:0] term;
  logic            tick;
  logic            fall_tick;
  logic            req_ok;

  // Half-period terminal count is D/2 - 1.
  assign term      = div_q[par_div_width-1:1] - CntW'(1);
  assign tick      = (cnt_q == term);
  assign fall_tick = tick & clk_div_q;
  assign req_ok    = ~i_div_value[0] && (i_div_value != '0) &&
                     (i_div_value >= par_div_width'(par_div_min));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    div_d     = div_q;
    pend_d    = pend_q;
    clk_div_d = clk_div_q;
    rst_div_d = rst_div_q;
    ce_rise_d = 1'b0;
    ce_fall_d = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    if (tick) begin
      cnt_d     = '0;
      clk_div_d = ~clk_div_q;
      // Divided-domain reset releases on the first falling toggle.
      rst_div_d = rst_div_q & ~clk_div_q;
      ce_rise_d = ~clk_div_q;
      ce_fall_d = clk_div_q;
    end

    case (state_q)
      StRun: begin
        if (i_div_req) begin
          if (req_ok) begin
            pend_d  = i_div_value;
            state_d = StDrain;
          end else begin
            ack_d = 1'b1;
            err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        // Only a falling toggle seen while already draining qualifies; load and restart.
        if (fall_tick) begin
          div_d     = pend_q;
          cnt_d     = '0;
          clk_div_d = 1'b0;
          rst_div_d = 1'b1;
          ce_fall_d = 1'b1;
          ack_d     = 1'b1;
          state_d   = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk_mhz or negedge i_rst_mhz) begin
    if (!i_rst_mhz) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      div_q     <= par_div_width'(par_div_default);
      pend_q    <= par_div_width'(par_div_default);
      clk_div_q <= 1'b0;
      rst_div_q <= 1'b1;
      ce_rise_q <= 1'b0;
      ce_fall_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      clk_div_q <= clk_div_d;
      rst_div_q <= rst_div_d;
      ce_rise_q <= ce_rise_d;
      ce_fall_q <= ce_fall_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign o_div_ack = ack_q;
  assign o_div_err = err_q;
  assign o_busy    = (state_q == StDrain);
  assign o_clk_div = clk_div_q;
  assign o_rst_div = rst_div_q;
  assign o_ce_rise = ce_rise_q;
  assign o_ce_fall = ce_fall_q;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Bench for clk_div_sequencer: edge-count timing model, request vector table and ack scoreboard.
module tb_clk_div_sequencer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         div_req = 1'b0;
  logic [W-1:0] div_value = '0;
  logic         div_ack, div_err, busy, clk_div, rst_div, ce_rise, ce_fall;

  clk_div_sequencer #(
    .par_div_width  (W),
    .par_div_default(8),
    .par_div_min    (4)
  ) dut (
    .i_clk_mhz  (clk),
    .i_rst_mhz  (rst_n),
    .i_div_req  (div_req),
    .i_div_value(div_value),
    .o_div_ack  (div_ack),
    .o_div_err  (div_err),
    .o_busy     (busy),
    .o_clk_div  (clk_div),
    .o_rst_div  (rst_div),
    .o_ce_rise  (ce_rise),
    .o_ce_fall  (ce_fall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] value;
    int           lead;
    bit           valid;
  } vec_t;

  typedef struct {
    int due;
    bit err;
  } ack_t;

  vec_t vecs[9];
  ack_t sbq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  // Model: n = edges since reset release or last load, d = active divisor.
  int n, d, pend_m;
  bit busy_m, loaded_now;

  function automatic logic [6:0] dut_vec();
    return {clk_div, rst_div, ce_rise, ce_fall, busy, div_ack, div_err};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b (clk,rst,rise,fall,busy,ack,err)",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_init();
    n = 0;
    d = 8;
    busy_m = 1'b0;
    loaded_now = 1'b0;
    sbq.delete();
  endtask

  task automatic step(input logic req, input logic [W-1:0] val, input bit valid);
    logic [6:0] exp;
    bit e_ack, e_err;
    div_req = req;
    div_value = val;
    @(posedge clk);
    cyc++;
    loaded_now = 1'b0;
    if (busy_m && ((n + 1) % d == 0)) begin
      d = pend_m;
      n = 0;
      busy_m = 1'b0;
      loaded_now = 1'b1;
      sbq.push_back('{cyc, 1'b0});
    end else begin
      n++;
      if (!busy_m && req) begin
        if (valid) begin
          busy_m = 1'b1;
          pend_m = int'(val);
        end else begin
          sbq.push_back('{cyc, 1'b1});
        end
      end
    end
    #1;
    e_ack = 1'b0;
    e_err = 1'b0;
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      e_ack = 1'b1;
      e_err = sbq[0].err;
      void'(sbq.pop_front());
    end
    exp = {((n % d) >= d / 2), (n < d), (n > 0 && (n % d) == d / 2),
           ((n > 0 && (n % d) == 0) || loaded_now), busy_m, e_ack, e_err};
    check("cycle", dut_vec(), exp);
    div_req = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b0);
  endtask

  task automatic settle(input int extra);
    int guard = 0;
    while ((busy_m || sbq.size() != 0) && guard < 600) begin
      step(1'b0, '0, 1'b0);
      guard++;
    end
    if (guard >= 600) begin
      total++;
      bad++;
      $display("FAIL settle_timeout cyc=%0d got=busy still set want=idle", cyc);
    end
    idle(extra);
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  initial begin
    vecs[0] = '{8'd5,   2, 1'b0};
    vecs[1] = '{8'd2,   1, 1'b0};
    vecs[2] = '{8'd0,   0, 1'b0};
    vecs[3] = '{8'd3,   4, 1'b0};
    vecs[4] = '{8'd6,   3, 1'b1};
    vecs[5] = '{8'd7,   1, 1'b0};
    vecs[6] = '{8'd10,  2, 1'b1};
    vecs[7] = '{8'd254, 5, 1'b1};
    vecs[8] = '{8'd8,   0, 1'b1};

    #3 rst_n = 1'b0;
    #1 check("reset_state", dut_vec(), 7'b0100000);
    reset_release();

    // Power-up timing at the default divisor.
    idle(26);

    // Shrink to 4 while the divided clock is high.
    for (int i = 0; i < 8 && !((n % d) >= d / 2); i++) idle(1);
    check("high_before_req", {clk_div, 6'b0}, 7'b1000000);
    step(1'b1, 8'd4, 1'b1);
    settle(12);

    for (int k = 0; k < 9; k++) begin
      idle(vecs[k].lead);
      step(1'b1, vecs[k].value, vecs[k].valid);
      settle(2 * d + 1);
    end

    // Second request while draining is dropped; then a fresh request lands.
    step(1'b1, 8'd6, 1'b1);
    step(1'b1, 8'd4, 1'b1);
    settle(14);
    step(1'b1, 8'd4, 1'b1);
    settle(10);

    // Acceptance on a falling-toggle edge waits a full old period.
    for (int i = 0; i < 8 && ((n + 1) % d != 0); i++) idle(1);
    step(1'b1, 8'd6, 1'b1);
    settle(14);

    // Async reset mid-drain abandons the request.
    step(1'b1, 8'd4, 1'b1);
    idle(1);
    check("busy_before_reset", {4'b0, busy, 2'b0}, 7'b0000100);
    rst_n = 1'b0;
    #2 check("reset_mid_drain", dut_vec(), 7'b0100000);
    reset_release();
    idle(26);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_div_sequencer.md
# clk_div_sequencer

Runtime-reconfigurable even-integer clock divider controller. Generates the divided clock, its synchronous divided-domain reset and single-cycle edge enables from the source clock, and sequences divisor changes through a request/acknowledge handshake. A change never produces a runt pulse: it is applied only at a completed low-going boundary and is followed by a fresh divided-domain reset. It sits between the board-level clock/reset and the peripheral pacing logic, such as the SPI/UART tick and the accelerometer sample timing.

## Interface
- par_div_width, 16: width of divisor and request value.
- par_div_default, 1000: divisor active after reset. Must be even and ≥ par_div_min.
- par_div_min, 4: smallest accepted divisor.
- i_clk_mhz  in  1: source clock; all logic is on its rising edge.
- i_rst_mhz  in  1: reset, asynchronous assert, active-low. Deassertion must be synchronized upstream.
- i_div_req  in  1: divisor change request; sampled only while o_busy = 0.
- i_div_value  in  par_div_width: requested divisor; captured in the cycle i_div_req is accepted.
- o_div_ack  out  1: one-cycle pulse; request completed or rejected.
- o_div_err  out  1: one-cycle pulse coincident with o_div_ack when the request is rejected.
- o_busy  out  1: valid request pending (DRAIN state).
- o_clk_div  out  1: divided clock, 50 % duty.
- o_rst_div  out  1: active-high reset for the divided domain.
- o_ce_rise  out  1: one-cycle pulse in the first source cycle that o_clk_div = 1.
- o_ce_fall  out  1: one-cycle pulse in the first source cycle that o_clk_div = 0 after a high phase.

## Operation
- **Async reset state:**
  - o_clk_div=0, o_rst_div=1, o_busy=0, o_div_ack=0, o_div_err=0, o_ce_rise=0, o_ce_fall=0.
  - Half-period counter = 0; active divisor = par_div_default; state RUN.
- **Half-period counter:**
  - Width par_div_width-1; terminal value = active divisor/2 − 1.
  - At terminal the counter wraps to 0 and toggles o_clk_div. Otherwise it increments.
- **Reset release in the divided domain:** on each toggle, o_rst_div ← o_rst_div AND NOT o_clk_div. o_rst_div therefore clears on the first falling toggle after (re)start.
- **States:**
  - RUN: divider free-running. If i_div_req=1:
    - Invalid request (odd, < par_div_min, or 0): pulse o_div_ack and o_div_err next cycle; stay in RUN; divisor unchanged; o_busy stays 0.
    - Valid request: capture i_div_value into the pending register; set o_busy; go to DRAIN.
  - DRAIN: divider keeps running on the old divisor. Only a falling toggle (o_clk_div 1→0) occurring after the acceptance edge counts. A toggle on the acceptance edge itself does not count. At the qualifying toggle:
    - Active divisor ← pending.
    - Counter ← 0.
    - o_clk_div ← 0; o_rst_div ← 1; o_ce_fall pulses.
    - o_div_ack pulses next cycle; o_busy clears with it.
    - Return to RUN.
- i_div_req while o_busy=1 is ignored and not queued. i_div_value is don't-care outside acceptance.
- A valid request is accepted even while o_rst_div=1 (start-up phase).
- Asynchronous reset mid-DRAIN abandons the request: no ack is issued and the divisor reverts to par_div_default.
- Largest usable divisor is 2^par_div_width − 2.

## Timing
- Edges are numbered n=1,2,… from reset release or from a divisor load. D = active divisor.
  - o_clk_div rises after edge D/2 and falls after edge D, then repeats with period D.
  - o_rst_div deasserts after edge D, together with the first fall.
- o_ce_rise/o_ce_fall are registered with the toggle: high in exactly the first cycle of each new level.
- Request→ack latency:
  - Rejection: 1 cycle.
  - Acceptance: cycles to the next qualifying falling toggle + 1. Worst case is D_old cycles + 1, when acceptance coincides with a falling toggle.
- After a load, the new divided domain sees one full high phase with o_rst_div=1, identical to post-reset.

## Test plan
1. par_div_default=8, par_div_width=8, par_div_min=4; release reset -> o_clk_div rises after edge 4 and falls after edge 8; o_rst_div 1→0 after edge 8; o_ce_rise high in cycle 5, o_ce_fall high in cycle 9; period 8 thereafter.
2. Running at D=8, o_clk_div high; pulse i_div_req with value 4 -> o_busy=1 until the next falling toggle. Then o_rst_div=1 and period 4 (rise after 2, fall after 4, o_rst_div clears at that fall). o_div_ack pulses one cycle after the load and o_busy clears with it.
3. Request value 5 -> o_div_ack=o_div_err=1 for exactly one cycle, one cycle after the request; o_busy never asserts; period stays 8; o_rst_div unchanged.
4. Request value 2, then value 0 -> each rejected as in scenario 3.
5. Valid request 6, then request 4 while o_busy=1 -> second request ignored; final period 6; single ack. A new request of 4 after the ack -> period 4.
6. Assert i_rst_mhz=0 mid-DRAIN -> immediately o_clk_div=0, o_rst_div=1, o_busy=0, no ack. After release, period is 8 (default) per scenario 1.
